// File: rtl/rmap_rx_pkg.sv
// Shared types and constants for the RMAP receive FIFO reader.
package rmap_rx_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DISCARD} rx_state_t;

  localparam logic [7:0] CTRL_EOP = 8'h00;
  localparam logic [7:0] CTRL_EEP = 8'h01;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       err;
    logic [7:0] data;
  } rx_beat_t;

  // Any control char other than EOP terminates the packet with an error.
  function automatic logic ctrl_is_error(input logic [8:0] word);
    return word[8] && ((word[7:0] == CTRL_EEP) || (word[7:0] != CTRL_EOP));
  endfunction

endpackage

// File: rtl/rmap_rx_fifo_reader_if.sv
// Valid/ready byte stream with packet framing, from the FIFO reader to the RMAP decoder.
interface rmap_rx_fifo_reader_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       out_err;

  modport master (
    output out_data, out_valid, out_sop, out_eop, out_err,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sop, out_eop, out_err,
    output out_ready
  );

endinterface

// File: rtl/rmap_rx_skid2.sv
// Two-entry skid buffer for raw FIFO words with same-cycle bypass of the arriving word,
// pop, and flush up to and including the first marker.
module rmap_rx_skid2
  import rmap_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [8:0] push_data,
  input  logic       pop,
  input  logic       flush,
  output logic       head_valid,
  output logic [8:0] head_data,
  output logic [1:0] occupancy,
  output logic       flush_hit
);

  logic [8:0] mem_reg [0:1];
  logic [1:0] occ_reg;
  logic [8:0] item [0:1];
  logic [1:0] n_items;
  logic [1:0] drop;
  logic [1:0] occ_next;

  // Logical queue view: stored entries first, then the word arriving this cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_item
      assign item[gi] = (occ_reg > 2'(gi)) ? mem_reg[gi] : push_data;
    end
  endgenerate

  assign n_items    = occ_reg + {1'b0, push};
  assign head_valid = (n_items != 2'd0);
  assign head_data  = item[0];
  assign occupancy  = occ_reg;

  always_comb begin
    drop      = {1'b0, pop};
    flush_hit = 1'b0;
    if (flush) begin
      drop = n_items;
      if (!pop && n_items != 2'd0 && item[0][8]) begin
        drop      = 2'd1;
        flush_hit = 1'b1;
      end else if (n_items == 2'd2 && item[1][8]) begin
        drop      = 2'd2;
        flush_hit = 1'b1;
      end
    end
    occ_next = n_items - drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_reg    <= 2'd0;
      mem_reg[0] <= 9'd0;
      mem_reg[1] <= 9'd0;
    end else begin
      occ_reg    <= occ_next;
      mem_reg[0] <= drop[0] ? item[1] : item[0];
      mem_reg[1] <= item[1];
    end
  end

endmodule

// File: rtl/rmap_rx_fifo_reader.sv
// RMAP receive FIFO read sequencer: FIFO reads, skid buffering, framing, length limit, discard.
// Optional statistics counters are built when RMAP_RX_STATS_EN is defined.
module rmap_rx_fifo_reader
  import rmap_rx_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MAX_PKT_LEN = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 fifo_rd_en,
  input  logic [8:0]           fifo_data,
  input  logic                 fifo_empty,
  input  logic                 discard_req,
  output logic [CNT_W-1:0]     pkt_len,
  output logic                 pkt_done,
  output logic                 busy,
`ifdef RMAP_RX_STATS_EN
  output logic [15:0]          stat_pkts,
  output logic [15:0]          stat_eep,
  output logic [15:0]          stat_trunc,
  output logic [15:0]          stat_disc,
`endif
  rmap_rx_fifo_reader_if.master st
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_LEN);

  rx_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] pkt_len_reg;
  logic             pkt_done_reg;
  logic             inflight_reg;

  logic       head_valid;
  logic [8:0] head_data;
  logic [1:0] occupancy;
  logic       flush_hit;
  logic       pop;
  logic       flush;
  logic       ctrl;
  logic       ovf;
  logic       xfer;
  rx_beat_t   beat;

  rmap_rx_skid2 u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data (fifo_data),
    .pop       (pop),
    .flush     (flush),
    .head_valid(head_valid),
    .head_data (head_data),
    .occupancy (occupancy),
    .flush_hit (flush_hit)
  );

  // The in-flight word counts against capacity so the buffer can never overrun.
  assign fifo_rd_en = rst_n && !fifo_empty && ((occupancy + {1'b0, inflight_reg}) < 2'd2);

  assign ctrl = head_data[8];
  assign ovf  = (state_reg == RUN) && !ctrl && (cnt_reg == MAX_CNT);

  always_comb begin
    beat      = '0;
    beat.sop  = (state_reg == IDLE);
    beat.eop  = ctrl || ovf;
    beat.err  = ctrl_is_error(head_data) || ovf;
    beat.data = (ctrl || ovf) ? 8'h00 : head_data[7:0];
  end

  assign st.out_valid = head_valid && (state_reg != DISCARD);
  assign st.out_sop   = st.out_valid && beat.sop;
  assign st.out_eop   = st.out_valid && beat.eop;
  assign st.out_err   = st.out_valid && beat.err;
  assign st.out_data  = st.out_valid ? beat.data : 8'h00;

  assign xfer = st.out_valid && st.out_ready;
  // The synthetic truncation beat is inserted ahead of the overflowing word; DISCARD drops that word.
  assign pop   = (xfer && !ovf) || (state_reg == DISCARD && head_valid);
  assign flush = discard_req && (state_reg == RUN) && !(xfer && beat.eop);

  assign pkt_len  = pkt_len_reg;
  assign pkt_done = pkt_done_reg;
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pkt_len_reg  <= '0;
      pkt_done_reg <= 1'b0;
      inflight_reg <= 1'b0;
    end else begin
      pkt_done_reg <= 1'b0;
      inflight_reg <= fifo_rd_en;
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            if (ctrl) begin
              pkt_len_reg  <= '0;
              pkt_done_reg <= 1'b1;
            end else begin
              cnt_reg   <= CNT_W'(1);
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (ovf) begin
              pkt_len_reg  <= MAX_CNT;
              pkt_done_reg <= 1'b1;
              cnt_reg      <= '0;
              state_reg    <= DISCARD;
            end else if (ctrl) begin
              pkt_len_reg  <= cnt_reg;
              pkt_done_reg <= 1'b1;
              cnt_reg      <= '0;
              state_reg    <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          if (flush) begin
            cnt_reg <= '0;
            if (flush_hit) begin
              pkt_done_reg <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              state_reg <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (head_valid && ctrl) begin
            pkt_done_reg <= 1'b1;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef RMAP_RX_STATS_EN
  logic [15:0] stat_reg [0:3];
  logic [3:0]  stat_inc;

  assign stat_inc[0] = xfer && beat.eop;
  assign stat_inc[1] = xfer && ctrl && beat.err;
  assign stat_inc[2] = xfer && ovf;
  assign stat_inc[3] = flush;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stat
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          stat_reg[gi] <= 16'h0000;
        end else if (stat_inc[gi] && stat_reg[gi] != 16'hFFFF) begin
          stat_reg[gi] <= stat_reg[gi] + 16'h0001;
        end
      end
    end
  endgenerate

  assign stat_pkts  = stat_reg[0];
  assign stat_eep   = stat_reg[1];
  assign stat_trunc = stat_reg[2];
  assign stat_disc  = stat_reg[3];
`endif

endmodule
